// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes and command-master state encoding
package axi4_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;
endpackage

// File: rtl/axi4_lite_cmd_master_if.sv
// axi4_lite_cmd_master_if: AXI4-Lite bus bundle between the command master and the register slaves
interface axi4_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: turns one valid/ready command at a time into an AXI4-Lite read or write
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter logic [ADDR_W-1:0] ADDR_LO = 32'h80000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  axi4_lite_cmd_master_if.master axi
);
  state_t state;
  logic   aw_done, w_done;
  logic   aw_fin, w_fin;
  assign aw_fin = aw_done | (axi.AWVALID & axi.AWREADY);
  assign w_fin  = w_done  | (axi.WVALID  & axi.WREADY);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= RESP_OKAY;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.AWADDR  <= '0;
      axi.AWVALID <= 1'b0;
      axi.WDATA   <= '0;
      axi.WVALID  <= 1'b0;
      axi.BREADY  <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARVALID <= 1'b0;
      axi.RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            // illegal addresses are answered locally and never reach the bus
            if (cmd_addr[1:0] != 2'b00 || cmd_addr < ADDR_LO) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_resp  <= RESP_SLVERR;
              rsp_rdata <= '0;
            end else if (cmd_write) begin
              state       <= WR;
              axi.AWADDR  <= cmd_addr;
              axi.WDATA   <= cmd_wdata;
              axi.AWVALID <= 1'b1;
              axi.WVALID  <= 1'b1;
            end else begin
              state       <= RD_AR;
              axi.ARADDR  <= cmd_addr;
              axi.ARVALID <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          axi.AWVALID <= axi.AWVALID & ~axi.AWREADY;
          axi.WVALID  <= axi.WVALID  & ~axi.WREADY;
          aw_done     <= aw_fin & ~w_fin;
          w_done      <= w_fin  & ~aw_fin;
          if (aw_fin && w_fin) begin
            state      <= WR_B;
            axi.BREADY <= 1'b1;
          end
        end
        WR_B: begin
          if (axi.BVALID) begin
            state      <= RSP;
            axi.BREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= axi.BRESP;
            rsp_rdata  <= '0;
          end
        end
        RD_AR: begin
          if (axi.ARREADY) begin
            state       <= RD_R;
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
          end
        end
        RD_R: begin
          if (axi.RVALID) begin
            state      <= RSP;
            axi.RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= axi.RRESP;
            rsp_rdata  <= axi.RDATA;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master: directed checks of the command master against a small AXI4-Lite slave model
module tb_axi4_lite_cmd_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int n_chk = 0, n_pass = 0;
  axi4_lite_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axi4_lite_cmd_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  logic [31:0] mem [64];
  int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  logic aw_pend = 0, w_pend = 0, ar_pend = 0, b_take = 0, r_take = 0;
  logic [31:0] aw_a, w_d, ar_a;
  int cyc = 0, aw_cyc = 0, w_cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, busy_cyc = 0, stab_err = 0;
  logic prev_wv = 0, prev_awv = 0;
  logic [31:0] prev_wd, prev_awa;
  initial begin
    foreach (mem[i]) mem[i] = '0;
    {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID} = '0;
    bus.BRESP = 2'b00; bus.RRESP = 2'b00; bus.RDATA = '0;
  end
  // slave outputs change only on the falling edge
  initial forever begin
    @(negedge clk);
    if (bus.AWVALID) begin bus.AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin bus.AWREADY = 1'b0; aw_cnt = 0; end
    if (bus.WVALID) begin bus.WREADY = (w_cnt >= w_dly); w_cnt++; end
    else begin bus.WREADY = 1'b0; w_cnt = 0; end
    bus.ARREADY = bus.ARVALID;
    if (b_take) begin bus.BVALID = 1'b0; b_take = 1'b0; end
    if (aw_pend && w_pend && !bus.BVALID) begin
      mem[aw_a[7:2]] = w_d;
      bus.BRESP  = (aw_a == 32'h80000040) ? 2'b10 : 2'b00;
      bus.BVALID = 1'b1;
      aw_pend = 1'b0; w_pend = 1'b0;
    end
    if (r_take) begin bus.RVALID = 1'b0; r_take = 1'b0; end
    if (ar_pend && !bus.RVALID) begin
      bus.RDATA = mem[ar_a[7:2]]; bus.RRESP = 2'b00; bus.RVALID = 1'b1; ar_pend = 1'b0;
    end
  end
  initial forever begin
    @(posedge clk);
    cyc++;
    if (bus.AWVALID && bus.AWREADY) begin aw_hs++; aw_cyc = cyc; aw_a = bus.AWADDR; aw_pend = 1'b1; end
    if (bus.WVALID && bus.WREADY) begin w_hs++; w_cyc = cyc; w_d = bus.WDATA; w_pend = 1'b1; end
    if (bus.BVALID && bus.BREADY) begin b_hs++; b_take = 1'b1; end
    if (bus.ARVALID && bus.ARREADY) begin ar_a = bus.ARADDR; ar_pend = 1'b1; end
    if (bus.RVALID && bus.RREADY) r_take = 1'b1;
    if (bus.AWVALID || bus.WVALID || bus.ARVALID) busy_cyc++;
    if ((bus.WVALID && prev_wv && bus.WDATA !== prev_wd) || (bus.AWVALID && prev_awv && bus.AWADDR !== prev_awa)) stab_err++;
    prev_wv = bus.WVALID; prev_wd = bus.WDATA; prev_awv = bus.AWVALID; prev_awa = bus.AWADDR;
  end
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic [1:0] rr, output logic rw, output int lat);
    int n;
    logic bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write; bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata !== rd || rsp_resp !== rr || rsp_write !== rw ||
          bus.AWVALID || bus.WVALID || bus.ARVALID) bad = 1'b1;
    end
    if (hold > 0) chk("rsp_stall_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rw;
    int          lat, a0, w0, b0, busy0, n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 0);
    chk("rst_readys", {bus.BREADY, bus.RREADY}, 0);
    chk("rst_addr_data", {bus.AWADDR, bus.ARADDR}, 0);
    #2 reset = 1'b1;
    do_cmd(1'b1, 32'h80000004, 32'hDEADBEEF, 0, rd, rr, rw, lat);
    chk("t1_latency", lat, 3);
    chk("t1_resp", rr, 2'b00);
    chk("t1_rsp_write", rw, 1);
    chk("t1_aw_w_same_cycle", aw_cyc, w_cyc);
    do_cmd(1'b0, 32'h80000004, 32'h0, 0, rd, rr, rw, lat);
    chk("t2_rdata", rd, 32'hDEADBEEF);
    chk("t2_resp", rr, 2'b00);
    chk("t2_rsp_write", rw, 0);
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; w_dly = 3;
    do_cmd(1'b1, 32'h80000010, 32'hCAFEF00D, 0, rd, rr, rw, lat);
    w_dly = 0;
    chk("t3_w_after_aw", w_cyc - aw_cyc, 3);
    chk("t3_aw_count", aw_hs - a0, 1);
    chk("t3_w_count", w_hs - w0, 1);
    chk("t3_b_count", b_hs - b0, 1);
    chk("t3_stable", stab_err, 0);
    chk("t3_resp", rr, 2'b00);
    chk("t3_mem", mem[4], 32'hCAFEF00D);
    busy0 = busy_cyc;
    do_cmd(1'b1, 32'h80000002, 32'h11111111, 0, rd, rr, rw, lat);
    chk("t4a_resp", rr, 2'b10);
    chk("t4a_rdata", rd, 0);
    chk("t4a_rsp_write", rw, 1);
    do_cmd(1'b0, 32'h7FFFFFFC, 32'h0, 0, rd, rr, rw, lat);
    chk("t4b_resp", rr, 2'b10);
    chk("t4b_rdata", rd, 0);
    chk("t4b_rsp_write", rw, 0);
    chk("t4_no_bus", busy_cyc - busy0, 0);
    do_cmd(1'b1, 32'h80000040, 32'h12345678, 5, rd, rr, rw, lat);
    chk("t5_resp", rr, 2'b10);
    chk("t5_idle_after", {cmd_ready, rsp_valid}, 2'b10);
    aw_dly = 100; w_dly = 100;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80000008; cmd_wdata = 32'h55AA55AA;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_awvalid_pre", {bus.AWVALID, bus.WVALID}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("t6_valids_async", {bus.AWVALID, bus.WVALID}, 2'b00);
    chk("t6_rsp_cmd", {rsp_valid, cmd_ready}, 2'b00);
    aw_dly = 0; w_dly = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    do_cmd(1'b0, 32'h80000004, 32'h0, 0, rd, rr, rw, lat);
    chk("t6_read_rdata", rd, 32'hDEADBEEF);
    chk("t6_read_resp", rr, 2'b00);
    chk("t6_mem_untouched", mem[2], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
